// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: ID/EX/MEM hazard inputs, memory
// handshake, halt/resume control and the stage-control outputs.
// The pipeline datapath is the master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_wreg;
    logic             ex_m2reg;
    logic [4:0]       ex_rn;
    logic             mem_wreg;
    logic             mem_m2reg;
    logic [4:0]       mem_rn;
    logic             id_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;
    logic             resume;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic             fault;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_wreg, ex_m2reg, ex_rn,
        output mem_wreg, mem_m2reg, mem_rn,
        output id_redirect, mem_req, mem_ready, halt_req, resume,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  ifid_flush, idex_bubble, memwb_bubble,
        input  fwd_a, fwd_b, state, fault, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_wreg, ex_m2reg, ex_rn,
        input  mem_wreg, mem_m2reg, mem_rn,
        input  id_redirect, mem_req, mem_ready, halt_req, resume,
        output pc_en, ifid_en, idex_en, exmem_en,
        output ifid_flush, idex_bubble, memwb_bubble,
        output fwd_a, fwd_b, state, fault, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for a five-stage pipeline: stage write enables,
// flushes and bubbles, operand forwarding selects, memory-wait timeout,
// drain/halt sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input logic                   clk,
    input logic                   resetn,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_DRAIN    = 2'b10,
        ST_HALTED   = 2'b11
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_FIRST = WAIT_W'(1);
    localparam logic [1:0]        DRAIN_LEN  = 2'd3;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        drain_q, drain_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  stall_q;

    logic       pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic       ifid_flush_c, idex_bubble_c, memwb_bubble_c;
    logic       run_eval;
    logic       mem_stall;
    logic       load_use;
    logic [1:0] fwd_a_c, fwd_b_c;

    // Youngest producer wins; a load still in EX cannot supply its data yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       src_used,
        input logic       ex_wreg,
        input logic       ex_m2reg,
        input logic [4:0] ex_rn,
        input logic       mem_wreg,
        input logic       mem_m2reg,
        input logic [4:0] mem_rn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src == 5'd0 || !src_used) begin
            sel = 2'b00;
        end else if (ex_wreg && !ex_m2reg && ex_rn == src) begin
            sel = 2'b01;
        end else if (mem_wreg && mem_rn == src) begin
            sel = mem_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    // Hazard detection and forwarding selects from the ID/EX/MEM pipeline info.
    always_comb begin
        mem_stall = hz.mem_req && !hz.mem_ready;
        load_use  = hz.ex_wreg && hz.ex_m2reg && (hz.ex_rn != 5'd0) &&
                    ((hz.id_use_rs && hz.id_rs == hz.ex_rn) ||
                     (hz.id_use_rt && hz.id_rt == hz.ex_rn));
        fwd_a_c   = fwd_sel(hz.id_rs, hz.id_use_rs, hz.ex_wreg, hz.ex_m2reg,
                            hz.ex_rn, hz.mem_wreg, hz.mem_m2reg, hz.mem_rn);
        fwd_b_c   = fwd_sel(hz.id_rt, hz.id_use_rt, hz.ex_wreg, hz.ex_m2reg,
                            hz.ex_rn, hz.mem_wreg, hz.mem_m2reg, hz.mem_rn);
    end

    // Next-state and stage-control decode; a completing memory wait reuses the RUN rules.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        drain_d        = drain_q;
        fault_d        = fault_q;
        pc_en_c        = 1'b0;
        ifid_en_c      = 1'b0;
        idex_en_c      = 1'b0;
        exmem_en_c     = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        memwb_bubble_c = 1'b0;
        run_eval       = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_eval = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    run_eval = 1'b1;
                end else begin
                    memwb_bubble_c = 1'b1;
                    if (wait_q == WAIT_LIMIT) begin
                        fault_d = 1'b1;
                        state_d = ST_HALTED;
                    end else begin
                        wait_d = wait_q + WAIT_FIRST;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_stall) begin
                    memwb_bubble_c = 1'b1;
                end else begin
                    ifid_en_c    = 1'b1;
                    idex_en_c    = 1'b1;
                    exmem_en_c   = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (drain_q == 2'd1) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end
            end
            default: begin
                idex_bubble_c  = 1'b1;
                memwb_bubble_c = 1'b1;
                if (hz.resume && !fault_q) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (run_eval) begin
            if (mem_stall) begin
                memwb_bubble_c = 1'b1;
                state_d        = ST_MEM_WAIT;
                wait_d         = WAIT_FIRST;
            end else if (hz.halt_req) begin
                ifid_en_c    = 1'b1;
                idex_en_c    = 1'b1;
                exmem_en_c   = 1'b1;
                ifid_flush_c = 1'b1;
                state_d      = ST_DRAIN;
                drain_d      = DRAIN_LEN;
            end else if (load_use) begin
                idex_en_c     = 1'b1;
                exmem_en_c    = 1'b1;
                idex_bubble_c = 1'b1;
                state_d       = ST_RUN;
            end else begin
                pc_en_c      = 1'b1;
                ifid_en_c    = 1'b1;
                idex_en_c    = 1'b1;
                exmem_en_c   = 1'b1;
                ifid_flush_c = hz.id_redirect;
                state_d      = ST_RUN;
            end
        end
    end

    // Sequencer state, timeout/drain counters, sticky fault and saturating stall count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            drain_q <= '0;
            fault_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            fault_q <= fault_d;
            if (!pc_en_c && stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    // While reset is held the pipeline is frozen and fed NOPs.
    assign hz.pc_en        = resetn & pc_en_c;
    assign hz.ifid_en      = resetn & ifid_en_c;
    assign hz.idex_en      = resetn & idex_en_c;
    assign hz.exmem_en     = resetn & exmem_en_c;
    assign hz.ifid_flush   = !resetn | ifid_flush_c;
    assign hz.idex_bubble  = !resetn | idex_bubble_c;
    assign hz.memwb_bubble = !resetn | memwb_bubble_c;
    assign hz.fwd_a        = resetn ? fwd_a_c : 2'b00;
    assign hz.fwd_b        = resetn ? fwd_b_c : 2'b00;
    assign hz.state        = state_q;
    assign hz.fault        = fault_q;
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl: a behavioural model
// predicts each cycle's outputs into a queue, a monitor compares at negedge.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W    = 6;
    localparam int WAIT_MAX = 15;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    localparam int M_RUN    = 0;
    localparam int M_WAIT   = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    typedef enum int {A_GO, A_REDIRECT, A_LOADUSE, A_HALTFILL, A_FREEZE, A_SLEEP} act_t;

    typedef struct packed {
        logic             pc_en;
        logic             ifid_en;
        logic             idex_en;
        logic             exmem_en;
        logic             ifid_flush;
        logic             idex_bubble;
        logic             memwb_bubble;
        logic [1:0]       fwd_a;
        logic [1:0]       fwd_b;
        logic [1:0]       state;
        logic             fault;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic clk;
    logic resetn;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    pipeline_hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz)
    );

    exp_t sb[$];
    int   total;
    int   bad;

    int   m_mode;
    int   m_wait;
    int   m_drain;
    bit   m_fault;
    int   m_stall;

    int   req_pct, ready_pct, halt_pct, resume_pct, reset_pct, redirect_pct;

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it when it disagrees.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Value an operand would receive: the most recent in-flight writer of the
    // register supplies it, except a load still in EX whose data is not ready.
    function automatic logic [1:0] model_fwd(input int src, input bit used);
        if (src == 0 || !used) return 2'b00;
        if (hz.ex_wreg && int'(hz.ex_rn) == src) begin
            if (!hz.ex_m2reg) return 2'b01;
        end
        if (hz.mem_wreg && int'(hz.mem_rn) == src) return hz.mem_m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(9, 0);
        if (r == 9) return 5'd31;
        return 5'(r % 4);
    endfunction

    // Drive one cycle of random inputs, predict the outputs and advance the model.
    task automatic applyStimulus(input bit do_reset);
        exp_t e;
        act_t act;
        bit   blocked, lu, freeze_ok;
        int   pc;

        hz.id_rs       = pick_reg();
        hz.id_rt       = pick_reg();
        hz.id_use_rs   = pct(80);
        hz.id_use_rt   = pct(60);
        hz.ex_wreg     = pct(60);
        hz.ex_m2reg    = pct(40);
        hz.ex_rn       = pick_reg();
        hz.mem_wreg    = pct(60);
        hz.mem_m2reg   = pct(40);
        hz.mem_rn      = pick_reg();
        hz.id_redirect = pct(redirect_pct);
        hz.mem_req     = pct(req_pct);
        hz.mem_ready   = pct(ready_pct);
        hz.halt_req    = pct(halt_pct);
        hz.resume      = pct(resume_pct);

        if (do_reset) begin
            resetn  = 1'b0;
            m_mode  = M_RUN;
            m_wait  = 0;
            m_drain = 0;
            m_fault = 1'b0;
            m_stall = 0;
            e = '0;
            e.ifid_flush   = 1'b1;
            e.idex_bubble  = 1'b1;
            e.memwb_bubble = 1'b1;
            sb.push_back(e);
            return;
        end
        resetn = 1'b1;

        e = '0;
        e.state = 2'(m_mode);
        e.fault = m_fault;
        e.stall = CNT_W'(m_stall);
        e.fwd_a = model_fwd(int'(hz.id_rs), hz.id_use_rs);
        e.fwd_b = model_fwd(int'(hz.id_rt), hz.id_use_rt);

        blocked = hz.mem_req && !hz.mem_ready;
        lu = 1'b0;
        if (hz.ex_wreg && hz.ex_m2reg && hz.ex_rn != 5'd0) begin
            if (hz.id_use_rs && hz.id_rs == hz.ex_rn) lu = 1'b1;
            if (hz.id_use_rt && hz.id_rt == hz.ex_rn) lu = 1'b1;
        end

        freeze_ok = (m_mode == M_RUN) || (m_mode == M_WAIT && hz.mem_ready);
        if (freeze_ok) begin
            if (blocked)          act = A_FREEZE;
            else if (hz.halt_req) act = A_HALTFILL;
            else if (lu)          act = A_LOADUSE;
            else if (hz.id_redirect) act = A_REDIRECT;
            else                  act = A_GO;
        end else if (m_mode == M_WAIT) begin
            act = A_FREEZE;
        end else if (m_mode == M_DRAIN) begin
            act = blocked ? A_FREEZE : A_HALTFILL;
        end else begin
            act = A_SLEEP;
        end

        case (act)
            A_GO:       begin e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; end
            A_REDIRECT: begin e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_flush = 1; end
            A_LOADUSE:  begin e.idex_en = 1; e.exmem_en = 1; e.idex_bubble = 1; end
            A_HALTFILL: begin e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_flush = 1; end
            A_FREEZE:   begin e.memwb_bubble = 1; end
            default:    begin e.idex_bubble = 1; e.memwb_bubble = 1; end
        endcase
        sb.push_back(e);

        if (act == A_FREEZE) begin
            if (freeze_ok) begin
                m_mode = M_WAIT;
                m_wait = 1;
            end else if (m_mode == M_WAIT) begin
                if (m_wait >= WAIT_MAX) begin
                    m_fault = 1'b1;
                    m_mode  = M_HALTED;
                end else begin
                    m_wait++;
                end
            end
        end else if (act == A_HALTFILL) begin
            if (freeze_ok) begin
                m_mode  = M_DRAIN;
                m_drain = 3;
            end else begin
                m_drain--;
                if (m_drain == 0) m_mode = M_HALTED;
            end
        end else if (act == A_SLEEP) begin
            if (hz.resume && !m_fault) m_mode = M_RUN;
        end else begin
            m_mode = M_RUN;
        end

        pc = int'(e.pc_en);
        if (pc == 0 && m_stall < CNT_SAT) m_stall++;
    endtask

    // Monitor: each negedge, pop the prediction for this cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pc_en",        int'(hz.pc_en),        int'(e.pc_en));
                checkOutput("ifid_en",      int'(hz.ifid_en),      int'(e.ifid_en));
                checkOutput("idex_en",      int'(hz.idex_en),      int'(e.idex_en));
                checkOutput("exmem_en",     int'(hz.exmem_en),     int'(e.exmem_en));
                checkOutput("ifid_flush",   int'(hz.ifid_flush),   int'(e.ifid_flush));
                checkOutput("idex_bubble",  int'(hz.idex_bubble),  int'(e.idex_bubble));
                checkOutput("memwb_bubble", int'(hz.memwb_bubble), int'(e.memwb_bubble));
                checkOutput("fwd_a",        int'(hz.fwd_a),        int'(e.fwd_a));
                checkOutput("fwd_b",        int'(hz.fwd_b),        int'(e.fwd_b));
                checkOutput("state",        int'(hz.state),        int'(e.state));
                checkOutput("fault",        int'(hz.fault),        int'(e.fault));
                checkOutput("stall_cycles", int'(hz.stall_cycles), int'(e.stall));
            end
        end
    end

    // Stimulus: reset, then phases biased toward stalls, timeouts, drains and saturation.
    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        req_pct = 0; ready_pct = 100; halt_pct = 0;
        resume_pct = 0; reset_pct = 0; redirect_pct = 0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1);
        end

        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin req_pct = 30; ready_pct = 60; halt_pct = 3;  resume_pct = 30; reset_pct = 1; redirect_pct = 25; end
                1: begin req_pct = 70; ready_pct = 4;  halt_pct = 2;  resume_pct = 30; reset_pct = 2; redirect_pct = 20; end
                2: begin req_pct = 20; ready_pct = 70; halt_pct = 25; resume_pct = 40; reset_pct = 4; redirect_pct = 20; end
                default: begin req_pct = 15; ready_pct = 70; halt_pct = 3; resume_pct = 50; reset_pct = 0; redirect_pct = 20; end
            endcase
            for (int c = 0; c < 800; c++) begin
                @(posedge clk); #1;
                applyStimulus(pct(reset_pct));
            end
        end

        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
